// File: rtl/mp_mem_pkg.sv
// rtl/mp_mem_pkg.sv - shared parameter defaults and FSM state type for mp_main_memory
package mp_mem_pkg;

    localparam int DEF_NPORTS  = 2;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TAG_W   = 2;
    localparam int DEF_LATENCY = 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mp_main_memory_if.sv
// rtl/mp_main_memory_if.sv - multi-port request/response bundle between cores and the shared memory
interface mp_main_memory_if #(
    parameter int NPORTS = mp_mem_pkg::DEF_NPORTS,
    parameter int ADDR_W = mp_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = mp_mem_pkg::DEF_DATA_W,
    parameter int TAG_W  = mp_mem_pkg::DEF_TAG_W
) ();

    logic [NPORTS-1:0]             req_valid;
    logic [NPORTS-1:0]             req_write;
    logic [NPORTS-1:0][ADDR_W-1:0] req_addr;
    logic [NPORTS-1:0][DATA_W-1:0] req_wdata;
    logic [NPORTS-1:0]             req_ready;
    logic [NPORTS-1:0]             rsp_valid;
    logic [NPORTS-1:0][DATA_W-1:0] rsp_rdata;
    logic [NPORTS-1:0][TAG_W-1:0]  rsp_tag;
    logic                          init_busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_tag, init_busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_tag, init_busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: one-hot grant to the first requester at or after the pointer
module rr_arbiter #(
    parameter int NPORTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req_i,
    output logic [NPORTS-1:0] grant_o
);

    localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx_w;
    logic             found;
    int               idx;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int off = 0; off < NPORTS; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NPORTS) begin
                idx = idx - NPORTS;
            end
            idx_w = PTR_W'(idx);
            if (!found && req_i[idx_w]) begin
                found          = 1'b1;
                grant_o[idx_w] = 1'b1;
                ptr_d          = (idx == NPORTS - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mp_main_memory.sv
// rtl/mp_main_memory.sv - single-ported shared memory with round-robin port arbitration,
// power-up clear sweep and a fixed-latency in-order response pipeline.
module mp_main_memory import mp_mem_pkg::*; #(
    parameter int NPORTS  = DEF_NPORTS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    mp_main_memory_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    mem_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              init_busy_q;

    logic [NPORTS-1:0] arb_req;
    logic [NPORTS-1:0] grant;

    logic              acc_valid;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] acc_rdata;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              pipe_vld_q  [LATENCY];
    logic [NPORTS-1:0] pipe_port_q [LATENCY];
    logic [TAG_W-1:0]  pipe_tag_q  [LATENCY];
    logic [DATA_W-1:0] pipe_data_q [LATENCY];

    logic [NPORTS-1:0]             rsp_valid_q;
    logic [NPORTS-1:0][DATA_W-1:0] rsp_rdata_q;
    logic [NPORTS-1:0][TAG_W-1:0]  rsp_tag_q;

    // Requests are invisible to the arbiter until the clear sweep is done.
    assign arb_req = (state_q == ST_RUN) ? bus.req_valid : '0;

    rr_arbiter #(
        .NPORTS (NPORTS)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (arb_req),
        .grant_o (grant)
    );

    assign bus.req_ready = grant;
    assign bus.init_busy = init_busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_tag   = rsp_tag_q;

    always_comb begin
        acc_valid = 1'b0;
        acc_write = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant[i]) begin
                acc_valid = 1'b1;
                acc_write = bus.req_write[i];
                acc_addr  = bus.req_addr[i];
                acc_wdata = bus.req_wdata[i];
            end
        end
    end

    // A write is echoed back as its response data.
    assign acc_rdata = acc_write ? acc_wdata : mem_q[acc_addr];

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = acc_addr;
        mem_wdata = acc_wdata;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (acc_valid && acc_write) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q     <= ST_RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Stage 0 captures the accept; the response register loads from the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < LATENCY; j++) begin
                pipe_vld_q[j] <= 1'b0;
            end
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_tag_q   <= '0;
        end else begin
            pipe_vld_q[0]  <= acc_valid;
            pipe_port_q[0] <= grant;
            pipe_tag_q[0]  <= acc_addr[ADDR_W-1 -: TAG_W];
            pipe_data_q[0] <= acc_rdata;
            for (int j = 1; j < LATENCY; j++) begin
                pipe_vld_q[j]  <= pipe_vld_q[j-1];
                pipe_port_q[j] <= pipe_port_q[j-1];
                pipe_tag_q[j]  <= pipe_tag_q[j-1];
                pipe_data_q[j] <= pipe_data_q[j-1];
            end
            for (int i = 0; i < NPORTS; i++) begin
                rsp_valid_q[i] <= pipe_vld_q[LATENCY-1] && pipe_port_q[LATENCY-1][i];
                if (pipe_vld_q[LATENCY-1] && pipe_port_q[LATENCY-1][i]) begin
                    rsp_rdata_q[i] <= pipe_data_q[LATENCY-1];
                    rsp_tag_q[i]   <= pipe_tag_q[LATENCY-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_mp_main_memory.sv
// tb/tb_mp_main_memory.sv - scoreboard bench for mp_main_memory (LATENCY=1 and LATENCY=3 builds)
module tb_mp_main_memory;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mp_main_memory_if #(.NPORTS(2), .ADDR_W(4), .DATA_W(32), .TAG_W(2)) bus1 ();
    mp_main_memory_if #(.NPORTS(2), .ADDR_W(4), .DATA_W(32), .TAG_W(2)) bus3 ();

    mp_main_memory #(.NPORTS(2), .ADDR_W(4), .DATA_W(32), .TAG_W(2), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mp_main_memory #(.NPORTS(2), .ADDR_W(4), .DATA_W(32), .TAG_W(2), .LATENCY(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        logic [1:0]  tag;
        int          edge_no;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int seen1 = 0;
    int last_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_rsp(input int lat, input int p, input logic [31:0] d, input logic [1:0] t);
        exp_t e;
        if ((lat == 1 && q1.size() == 0) || (lat == 3 && q3.size() == 0)) begin
            n_chk++;
            $display("FAIL unexpected response L%0d port %0d data 0x%0h: got a strobe, expected none", lat, p, d);
            return;
        end
        if (lat == 1) e = q1.pop_front();
        else e = q3.pop_front();
        chk($sformatf("L%0d rsp port", lat), p, e.port);
        chk($sformatf("L%0d rsp data", lat), d, e.data);
        chk($sformatf("L%0d rsp tag", lat), t, e.tag);
        chk($sformatf("L%0d rsp latency", lat), cyc, e.edge_no + lat);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bus1.rsp_valid[i] === 1'b1) begin
                seen1++;
                check_rsp(1, i, bus1.rsp_rdata[i], bus1.rsp_tag[i]);
            end
            if (bus3.rsp_valid[i] === 1'b1) begin
                check_rsp(3, i, bus3.rsp_rdata[i], bus3.rsp_tag[i]);
            end
        end
    end

    task automatic clear_req(input int lat);
        if (lat == 1) bus1.req_valid = '0;
        else bus3.req_valid = '0;
    endtask

    task automatic set_req(input int lat, input int p, input bit w, input logic [3:0] a, input logic [31:0] d);
        if (lat == 1) begin
            bus1.req_valid    = '0;
            bus1.req_valid[p] = 1'b1;
            bus1.req_write[p] = w;
            bus1.req_addr[p]  = a;
            bus1.req_wdata[p] = d;
        end else begin
            bus3.req_valid    = '0;
            bus3.req_valid[p] = 1'b1;
            bus3.req_write[p] = w;
            bus3.req_addr[p]  = a;
            bus3.req_wdata[p] = d;
        end
    endtask

    function automatic bit get_ready(input int lat, input int p);
        return (lat == 1) ? bus1.req_ready[p] : bus3.req_ready[p];
    endfunction

    task automatic issue(input int lat, input int p, input bit w, input logic [3:0] a,
                         input logic [31:0] d, input logic [31:0] exp_d);
        int   n;
        bit   rdy;
        exp_t e;
        n = 0;
        @(negedge clk);
        set_req(lat, p, w, a, d);
        #1;
        rdy = get_ready(lat, p);
        while (!rdy && n < 50) begin
            @(negedge clk);
            #1;
            rdy = get_ready(lat, p);
            n++;
        end
        if (!rdy) begin
            n_chk++;
            $display("FAIL issue timeout L%0d port %0d addr %0d: got no ready, expected ready", lat, p, a);
            clear_req(lat);
            return;
        end
        e.port    = p;
        e.data    = exp_d;
        e.tag     = a[3:2];
        e.edge_no = cyc + 1;
        last_edge = e.edge_no;
        if (lat == 1) q1.push_back(e);
        else q3.push_back(e);
    endtask

    task automatic idle(input int lat);
        @(negedge clk);
        clear_req(lat);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        bus1.req_valid = '0;
        bus3.req_valid = '0;
        q1.delete();
        q3.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at the negedge just after the reset edge; holds both requests high throughout.
    task automatic check_init(input string name);
        int n;
        int bad;
        n = 0;
        bad = 0;
        bus1.req_valid = 2'b11;
        bus1.req_write = 2'b00;
        bus1.req_addr[0] = 4'd0;
        bus1.req_addr[1] = 4'd1;
        #1;
        while (bus1.init_busy === 1'b1 && n < 40) begin
            if (bus1.req_ready !== 2'b00) bad++;
            n++;
            @(negedge clk);
            #1;
        end
        bus1.req_valid = '0;
        chk({name, " busy cycles"}, n, 16);
        chk({name, " ready during init"}, bad, 0);
    endtask

    initial begin
        int s;
        int e1;
        logic [1:0] g;
        bus1.req_valid = '0;
        bus1.req_write = '0;
        bus1.req_addr  = '0;
        bus1.req_wdata = '0;
        bus3.req_valid = '0;
        bus3.req_write = '0;
        bus3.req_addr  = '0;
        bus3.req_wdata = '0;

        pulse_rst();
        #1;
        chk("reset rsp_valid", bus1.rsp_valid, 0);
        chk("reset rsp_rdata", bus1.rsp_rdata, 0);
        chk("reset rsp_tag", bus1.rsp_tag, 0);
        chk("reset init_busy", bus1.init_busy, 1);
        chk("reset L3 rsp_valid", bus3.rsp_valid, 0);
        check_init("init");

        // Contention: both ports hold reads; grants alternate starting from port 0.
        @(negedge clk);
        bus1.req_valid    = 2'b11;
        bus1.req_write    = 2'b00;
        bus1.req_addr[0]  = 4'd2;
        bus1.req_addr[1]  = 4'd7;
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            #1;
            g = bus1.req_ready;
            chk($sformatf("contention grant %0d", k), g, (k % 2 == 0) ? 2'b01 : 2'b10);
            e.edge_no = cyc + 1;
            e.data    = 32'h0;
            if (g[0]) begin e.port = 0; e.tag = 2'b00; q1.push_back(e); end
            if (g[1]) begin e.port = 1; e.tag = 2'b01; q1.push_back(e); end
            @(negedge clk);
        end
        bus1.req_valid = '0;

        for (int a = 0; a < 16; a++) begin
            issue(1, 0, 1'b0, 4'(a), 32'h0, 32'h0);
        end
        idle(1);

        issue(1, 0, 1'b1, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        issue(1, 1, 1'b0, 4'd5, 32'h0, 32'hDEADBEEF);
        issue(1, 1, 1'b1, 4'd15, 32'h0000000F, 32'h0000000F);
        issue(1, 0, 1'b0, 4'd15, 32'h0, 32'h0000000F);
        issue(1, 1, 1'b0, 4'd0, 32'h0, 32'h0);
        idle(1);
        repeat (3) @(negedge clk);

        // Reset in the cycle after an accept: that response must never appear.
        s = seen1;
        issue(1, 0, 1'b0, 4'd5, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        bus1.req_valid = '0;
        rst = 1'b1;
        q1.delete();
        q3.delete();
        @(negedge clk);
        rst = 1'b0;
        check_init("reinit");
        chk("mid-flight responses", seen1 - s, 0);
        issue(1, 0, 1'b0, 4'd5, 32'h0, 32'h0);
        idle(1);

        issue(3, 1, 1'b1, 4'd1, 32'h11, 32'h11);
        issue(3, 1, 1'b1, 4'd2, 32'h22, 32'h22);
        issue(3, 1, 1'b1, 4'd3, 32'h33, 32'h33);
        issue(3, 0, 1'b0, 4'd1, 32'h0, 32'h11);
        e1 = last_edge;
        issue(3, 0, 1'b0, 4'd2, 32'h0, 32'h22);
        issue(3, 0, 1'b0, 4'd3, 32'h0, 32'h33);
        chk("L3 back-to-back accepts", last_edge - e1, 2);
        idle(3);

        repeat (8) @(negedge clk);
        #1;
        chk("L1 queue drained", q1.size(), 0);
        chk("L3 queue drained", q3.size(), 0);
        chk("L3 hold rdata p0", bus3.rsp_rdata[0], 32'h33);
        chk("L3 hold rdata p1", bus3.rsp_rdata[1], 32'h33);
        chk("L3 hold tag p0", bus3.rsp_tag[0], 2'b00);
        chk("idle rsp_valid", {bus1.rsp_valid, bus3.rsp_valid}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mp_main_memory.md
MP_MAIN_MEMORY -- requirements
Module: mp_main_memory

Interface
REQ-001 SHALL take parameter NPORTS, default 2, giving the number of requesting cores/ports (>=1).
REQ-002 SHALL take parameter ADDR_W, default 4, giving the word-address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL take parameter DATA_W, default 32, giving the word width.
REQ-004 SHALL take parameter TAG_W, default 2, giving the tag width; TAG_W <= ADDR_W.
REQ-005 SHALL take parameter LATENCY, default 1, giving the accept-to-response cycles (>=1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port req_valid, input, [NPORTS]: per-port request present.
REQ-009 SHALL have port req_write, input, [NPORTS]: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, [NPORTS][ADDR_W]: word address.
REQ-011 SHALL have port req_wdata, input, [NPORTS][DATA_W]: write data.
REQ-012 SHALL have port req_ready, output, [NPORTS]: request accepted this cycle.
REQ-013 SHALL have port rsp_valid, output, [NPORTS]: one-cycle response strobe.
REQ-014 SHALL have port rsp_rdata, output, [NPORTS][DATA_W]: read data, or the written data echoed back.
REQ-015 SHALL have port rsp_tag, output, [NPORTS][TAG_W]: req_addr[ADDR_W-1 -: TAG_W] of the originating request.
REQ-016 SHALL have port init_busy, output, 1 bit: high while the memory is being cleared.

Function
REQ-017 SHALL implement a single-ported DEPTH x DATA_W array: at most one access per cycle.
REQ-018 SHALL use a two-state FSM: INIT, then RUN.
- INIT: sweeps the address counter 0..DEPTH-1, writing 0, one word per cycle.
- INIT -> RUN: after the edge that writes word DEPTH-1.
- RUN: remains until rst.
REQ-019 SHALL hold req_ready all-zero in INIT; init_busy = (state==INIT).
REQ-020 SHALL in RUN assert req_ready[i] combinationally, only for the port granted by a round-robin arbiter over req_valid; at most one bit is set.
REQ-021 SHALL grant the first requesting port at or after the rotating pointer.
- On a grant to port g, the pointer becomes (g+1) mod NPORTS.
- With no grant, the pointer holds.
REQ-022 SHALL define a request accepted at edge k as req_valid[i] && req_ready[i] at that edge.
- A write updates the array at edge k.
- A read samples the array at edge k.
- A read in any later cycle observes that write.
REQ-023 SHALL for an accepted request raise rsp_valid[i] for exactly one cycle, registered at edge k+LATENCY.
- rsp_rdata[i] and rsp_tag[i] are valid in that cycle.
- Throughput is one accept per cycle across all ports.
REQ-024 SHALL carry port id, tag and data through a LATENCY-deep pipeline; responses are in accept order and there is no response backpressure.
REQ-025 SHALL hold rsp_rdata/rsp_tag at their last values when rsp_valid is low.
REQ-026 SHALL ignore a req_valid that is not granted; requesters hold their request until ready.
REQ-027 SHALL accept every address 0..DEPTH-1 (the full range is legal); no out-of-range case exists.

Reset
REQ-028 SHALL on rst:
- state <= INIT, address counter <= 0, arbiter pointer <= 0;
- all pipeline valid bits <= 0, rsp_valid <= 0, rsp_rdata <= 0, rsp_tag <= 0.
REQ-029 SHALL on rst asserted mid-operation (RUN or INIT):
- drop in-flight responses (never delivered);
- restart the full DEPTH-cycle clear.

Structure
REQ-030 SHALL place the FSM state enum (INIT, RUN) and the parameter defaults in the shared package mp_mem_pkg.
REQ-031 SHALL implement the arbiter as sub-module rr_arbiter (NPORTS, req in, one-hot grant out, pointer state inside).

Verification (NPORTS=2, ADDR_W=4, DATA_W=32, TAG_W=2, LATENCY=1 unless stated)
REQ-032 SHALL cover init: rst for 1 cycle -> init_busy high and req_ready=0 for 16 cycles; then reads of all 16 addresses return 0.
REQ-033 SHALL cover write then read: port0 writes 0xDEADBEEF to addr 5; port1 then reads addr 5 -> rsp_valid[1] one cycle after accept, rdata 0xDEADBEEF, tag 2'b01.
REQ-034 SHALL cover contention: both ports hold reads continuously -> grants alternate 0,1,0,1; each port gets one response per 2 cycles.
REQ-035 SHALL cover tag/boundary: read addr 15 after writing 0x0000000F -> rdata 0x0000000F, tag 2'b11; addr 0 -> tag 2'b00.
REQ-036 SHALL cover reset mid-flight: rst in the cycle after an accept -> no rsp_valid appears; init_busy high again for 16 cycles.
REQ-037 SHALL cover the LATENCY=3 build: back-to-back reads of addrs 1,2,3 from port0 -> rsp_valid[0] high 3 cycles after each accept, 3 consecutive cycles, in order.
